// File: rtl/game_round_timer.sv
// Round timer for the game FSM: a zombie-spawn window whose length depends on
// the difficulty mode latched at round start, followed by a fixed grace window.
// Produces a phase code, a ticks-remaining count, a level "spawning closed"
// flag, and one-cycle warning / end-of-round pulses, all registered together
// with the state.
module game_round_timer #(
    parameter int                       CNT_W        = 7,
    parameter int                       MODES        = 4,
    parameter logic [CNT_W*MODES-1:0]   SPAWN_LEN    = {7'd60, 7'd40, 7'd25, 7'd15},
    parameter int                       GRACE_LEN    = 5,
    parameter int                       WARN_LEN     = 3,
    parameter bit                       AUTO_RESTART = 1'b0,
    localparam int                      MODE_W       = $clog2(MODES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              run,
    input  logic              pause,
    input  logic              clear,
    input  logic [MODE_W-1:0] mode,
    output logic [1:0]        phase,
    output logic [CNT_W-1:0]  remaining,
    output logic              spawn_closed,
    output logic              warn_pulse,
    output logic              round_end_pulse
);

    localparam logic [1:0] PH_IDLE  = 2'b00;
    localparam logic [1:0] PH_SPAWN = 2'b01;
    localparam logic [1:0] PH_GRACE = 2'b10;
    localparam logic [1:0] PH_DONE  = 2'b11;

    localparam logic [CNT_W-1:0]  GRACE_C = CNT_W'(GRACE_LEN);
    localparam logic [CNT_W-1:0]  WARN_C  = CNT_W'(WARN_LEN);
    localparam logic [MODE_W:0]   MODES_C = (MODE_W + 1)'(MODES);

    logic [1:0]        phase_reg, phase_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [MODE_W-1:0] mode_reg, mode_next;
    logic              closed_reg, closed_next;
    logic              warn_reg, warn_next;
    logic              end_reg, end_next;

    // Per-mode spawn lengths, with a zero length promoted to one tick so a
    // window always lasts at least one tick.
    logic [CNT_W-1:0] spawn_len_arr [MODES];

    generate
        for (genvar gi = 0; gi < MODES; gi++) begin : g_len
            assign spawn_len_arr[gi] = (SPAWN_LEN[gi*CNT_W +: CNT_W] == '0)
                                     ? CNT_W'(1)
                                     : SPAWN_LEN[gi*CNT_W +: CNT_W];
        end
    endgenerate

    logic [CNT_W-1:0] len_cur;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] warn_at;
    logic             warn_en;
    logic             mode_ok;

    assign len_cur = spawn_len_arr[mode_reg];
    assign cnt_inc = cnt_reg + 1'b1;
    assign warn_at = len_cur - WARN_C;
    // A warning only makes sense if it lands strictly inside the spawn window.
    assign warn_en = (WARN_C != '0) && (WARN_C < len_cur);
    // Out-of-range difficulty requests fall back to mode 0.
    assign mode_ok = ({1'b0, mode} < MODES_C);

    // State register: phase, counter, latched mode and all registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg  <= PH_IDLE;
            cnt_reg    <= '0;
            mode_reg   <= '0;
            closed_reg <= 1'b0;
            warn_reg   <= 1'b0;
            end_reg    <= 1'b0;
        end else begin
            phase_reg  <= phase_next;
            cnt_reg    <= cnt_next;
            mode_reg   <= mode_next;
            closed_reg <= closed_next;
            warn_reg   <= warn_next;
            end_reg    <= end_next;
        end
    end

    // Next-state logic, priority clear > run low > pause > tick.
    always_comb begin
        phase_next  = phase_reg;
        cnt_next    = cnt_reg;
        mode_next   = mode_reg;
        closed_next = closed_reg;
        warn_next   = 1'b0;
        end_next    = 1'b0;
        if (clear || (!run && (phase_reg != PH_IDLE))) begin
            phase_next  = PH_IDLE;
            cnt_next    = '0;
            closed_next = 1'b0;
        end else if (run && ((phase_reg == PH_IDLE) ||
                             ((phase_reg == PH_DONE) && (AUTO_RESTART == 1'b1)))) begin
            // Round start: any tick in this cycle is deliberately not counted.
            mode_next   = mode_ok ? mode : '0;
            cnt_next    = '0;
            closed_next = 1'b0;
            phase_next  = PH_SPAWN;
        end else if (tick && !pause) begin
            case (phase_reg)
                PH_SPAWN: begin
                    if (warn_en && (cnt_inc == warn_at)) begin
                        warn_next = 1'b1;
                    end
                    if (cnt_inc == len_cur) begin
                        cnt_next    = '0;
                        closed_next = 1'b1;
                        if (GRACE_C == '0) begin
                            phase_next = PH_DONE;
                            end_next   = 1'b1;
                        end else begin
                            phase_next = PH_GRACE;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                PH_GRACE: begin
                    if (cnt_inc == GRACE_C) begin
                        phase_next = PH_DONE;
                        cnt_next   = '0;
                        end_next   = 1'b1;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: flags straight from registers, remaining derived from the counter.
    always_comb begin
        remaining = '0;
        case (phase_reg)
            PH_SPAWN: remaining = len_cur - cnt_reg;
            PH_GRACE: remaining = GRACE_C - cnt_reg;
            default:  remaining = '0;
        endcase
        phase           = phase_reg;
        spawn_closed    = closed_reg;
        warn_pulse      = warn_reg;
        round_end_pulse = end_reg;
    end

endmodule

// File: tb/tb_game_round_timer.sv
// Bench for game_round_timer: three builds (default, auto-restart, 3-mode) share
// one stimulus stream and are compared against an elapsed-tick model of a round.
module tb_game_round_timer;

    localparam int GRACE = 5;
    localparam int WARN  = 3;

    logic       clk = 1'b0;
    logic       rst, tick, run, pause, clear;
    logic [1:0] mode;
    logic [1:0] phase_a, phase_b, phase_c;
    logic [6:0] rem_a, rem_b, rem_c;
    logic       closed_a, closed_b, closed_c;
    logic       warn_a, warn_b, warn_c;
    logic       rend_a, rend_b, rend_c;

    always #5 clk = ~clk;

    game_round_timer dut_a (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .pause(pause), .clear(clear),
        .mode(mode), .phase(phase_a), .remaining(rem_a), .spawn_closed(closed_a),
        .warn_pulse(warn_a), .round_end_pulse(rend_a)
    );

    game_round_timer #(.AUTO_RESTART(1'b1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .pause(pause), .clear(clear),
        .mode(mode), .phase(phase_b), .remaining(rem_b), .spawn_closed(closed_b),
        .warn_pulse(warn_b), .round_end_pulse(rend_b)
    );

    game_round_timer #(.MODES(3), .SPAWN_LEN({7'd40, 7'd25, 7'd15})) dut_c (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .pause(pause), .clear(clear),
        .mode(mode), .phase(phase_c), .remaining(rem_c), .spawn_closed(closed_c),
        .warn_pulse(warn_c), .round_end_pulse(rend_c)
    );

    int tests = 0;
    int fails = 0;

    // Round model: st 0 idle / 1 spawn / 2 grace / 3 done; n = ticks counted this round.
    typedef struct {
        int st;
        int n;
        int len;
        bit warn;
        bit rend;
    } model_t;

    model_t ma, mb, mc;
    int lens[4] = '{15, 25, 40, 60};

    function automatic int len_of(int md, int nm);
        return (md >= nm) ? lens[0] : lens[md];
    endfunction

    function automatic model_t step(model_t m, bit ar, int nm, bit c, bit r, bit p, bit t, int md);
        model_t q = m;
        q.warn = 1'b0;
        q.rend = 1'b0;
        if (c || (!r && m.st != 0)) begin
            q.st = 0;
            q.n  = 0;
        end else if (m.st == 0 || (m.st == 3 && ar)) begin
            if (r) begin
                q.st  = 1;
                q.n   = 0;
                q.len = len_of(md, nm);
            end
        end else if (m.st != 3 && t && !p) begin
            q.n = m.n + 1;
            if (WARN != 0 && WARN < q.len && q.n == q.len - WARN) q.warn = 1'b1;
            if (q.n == q.len + GRACE) begin
                q.st   = 3;
                q.rend = 1'b1;
            end else if (q.n >= q.len) begin
                q.st = 2;
            end
        end
        return q;
    endfunction

    function automatic int mrem(model_t m);
        if (m.st == 1) return m.len - m.n;
        if (m.st == 2) return m.len + GRACE - m.n;
        return 0;
    endfunction

    task automatic cmp(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_models();
        cmp("a.phase",  phase_a,  ma.st);     cmp("a.remaining", rem_a, mrem(ma));
        cmp("a.closed", closed_a, ma.st >= 2); cmp("a.warn", warn_a, ma.warn); cmp("a.rend", rend_a, ma.rend);
        cmp("b.phase",  phase_b,  mb.st);     cmp("b.remaining", rem_b, mrem(mb));
        cmp("b.closed", closed_b, mb.st >= 2); cmp("b.warn", warn_b, mb.warn); cmp("b.rend", rend_b, mb.rend);
        cmp("c.phase",  phase_c,  mc.st);     cmp("c.remaining", rem_c, mrem(mc));
        cmp("c.closed", closed_c, mc.st >= 2); cmp("c.warn", warn_c, mc.warn); cmp("c.rend", rend_c, mc.rend);
    endtask

    task automatic model_reset();
        ma = '{0, 0, 1, 1'b0, 1'b0};
        mb = ma;
        mc = ma;
    endtask

    // Apply one cycle of inputs, advance the models on the edge, compare after it.
    task automatic drive(bit c, bit r, bit p, bit t, logic [1:0] md, bit chk);
        clear = c; run = r; pause = p; tick = t; mode = md;
        @(posedge clk);
        ma = step(ma, 1'b0, 4, c, r, p, t, int'(md));
        mb = step(mb, 1'b1, 4, c, r, p, t, int'(md));
        mc = step(mc, 1'b0, 3, c, r, p, t, int'(md));
        #1;
        if (chk) check_models();
        $display("[TB] clr=%0b run=%0b pause=%0b tick=%0b mode=%0d | a ph=%0d rem=%0d | b ph=%0d rem=%0d | c ph=%0d rem=%0d",
                 c, r, p, t, md, phase_a, rem_a, phase_b, rem_b, phase_c, rem_c);
    endtask

    typedef struct {
        bit         c, r, p, t;
        logic [1:0] md;
        int         ph, rem;
        bit         cl, w, e;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // start with tick (ignored), count, idle cycle, paused tick, mode change ignored
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1, 15, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1, 14, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1, 14, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1, 14, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 1, 13, 1'b0, 1'b0, 1'b0};
        // run drop returns to idle; restart in mode 3; clear beats run and tick
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1, 60, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 0, 0,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0,  1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1, 25, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1, 24, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 0, 0,  1'b0, 1'b0, 1'b0};

        rst = 1'b1; tick = 1'b0; run = 1'b0; pause = 1'b0; clear = 1'b0; mode = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset.phase", phase_a, 0);     cmp("reset.remaining", rem_a, 0);
        cmp("reset.closed", closed_a, 0);   cmp("reset.warn", warn_a, 0);
        cmp("reset.rend", rend_a, 0);
        rst = 1'b0;

        // Vector table on the default build
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].c, vecs[i].r, vecs[i].p, vecs[i].t, vecs[i].md, 1'b0);
            cmp($sformatf("vec%0d.phase", i),     phase_a,  vecs[i].ph);
            cmp($sformatf("vec%0d.remaining", i), rem_a,    vecs[i].rem);
            cmp($sformatf("vec%0d.closed", i),    closed_a, vecs[i].cl);
            cmp($sformatf("vec%0d.warn", i),      warn_a,   vecs[i].w);
            cmp($sformatf("vec%0d.rend", i),      rend_a,   vecs[i].e);
        end

        // Full mode-0 round, plus auto-restart on dut_b
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
            if (i == 12) cmp("s1.warn_at_12", warn_a, 1);
            if (i == 15) begin
                cmp("s1.phase_at_15", phase_a, 2);
                cmp("s1.closed_at_15", closed_a, 1);
            end
            if (i == 20) begin
                cmp("s1.rend_at_20", rend_a, 1);
                cmp("s1.phase_at_20", phase_a, 3);
                cmp("s1.rem_at_20", rem_a, 0);
                cmp("s1.b_rend_at_20", rend_b, 1);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        cmp("s1.rend_width", rend_a, 0);
        cmp("s1.done_hold_closed", closed_a, 1);
        cmp("s1.b_restart_phase", phase_b, 1);
        cmp("s1.b_restart_closed", closed_b, 0);
        for (int i = 1; i <= 20; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
        cmp("s1.b_second_rend", rend_b, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Pause mid-spawn in mode 2 (40 ticks)
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1);
        cmp("s2.rem_paused", rem_a, 30);
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        cmp("s2.closed_after_40", closed_a, 1);

        // Clear with tick while in grace
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        cmp("s3.phase_idle", phase_a, 0);
        cmp("s3.closed_low", closed_a, 0);
        cmp("s3.no_rend", rend_a, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Mode switch mid-round; dut_c treats mode 3 as out of range
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1, (i >= 5) ? 2'd0 : 2'd3, 1'b1);
            if (i == 15) cmp("s4.c_closed_at_15", closed_c, 1);
            if (i == 59) cmp("s4.phase_at_59", phase_a, 1);
            if (i == 60) cmp("s4.phase_at_60", phase_a, 2);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Tick with start ignored, then async reset in grace
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
        cmp("s6.start_rem", rem_a, 25);
        for (int i = 0; i < 27; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
        cmp("s6.in_grace", phase_a, 2);
        rst = 1'b1;
        #1;
        cmp("s6.rst_phase", phase_a, 0);     cmp("s6.rst_remaining", rem_a, 0);
        cmp("s6.rst_closed", closed_a, 0);   cmp("s6.rst_b_phase", phase_b, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_models();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 49) != 0,
                  $urandom_range(0, 4) == 0,
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
